// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and encodings for the RV32I multi-cycle control sequencer
//   state_t        FSM states FETCH..TRAP
//   OP_*           supported major opcodes
//   ALU_*, IMM_*, WB_*, JMP_*, TRAP_*   control-bus field encodings
//   alu_op()       funct3 (+ funct7[5] alternate bit) to ALU code
package cpu_ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;
    localparam logic [1:0] JMP_SEQ  = 2'd0;
    localparam logic [1:0] JMP_JAL  = 2'd1;
    localparam logic [1:0] JMP_JALR = 2'd2;
    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_MEM     = 2'd2;
    // alt selects SUB over ADD and SRA over SRL; funct3 011 (SLTU) is rejected by the decoder
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational main decoder, instruction word -> control bus + class flags
//   i_inst   [31:0] instruction word
//   o_alu    [3:0]  ALU code        o_imm  [2:0] immediate format
//   o_m2r    [1:0]  write-back src  o_srcb       ALU B = immediate
//   o_jump   [1:0]  jump kind       o_br / o_brn BEQ / BNE
//   o_ill           unsupported opcode or funct3
//   o_ld / o_st / o_is_br   load, store, conditional-branch class
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [3:0]  o_alu,
    output logic [2:0]  o_imm,
    output logic [1:0]  o_m2r,
    output logic        o_srcb,
    output logic [1:0]  o_jump,
    output logic        o_br,
    output logic        o_brn,
    output logic        o_ill,
    output logic        o_ld,
    output logic        o_st,
    output logic        o_is_br
);
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_alt;
    logic       w_unused;
    assign w_op  = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign w_alt = i_inst[30];
    // register indices and the remaining funct7/immediate bits belong to the datapath
    assign w_unused = ^{i_inst[31], i_inst[29:15], i_inst[11:7]};
    always_comb begin
        o_alu   = '0;
        o_imm   = IMM_I;
        o_m2r   = WB_ALU;
        o_srcb  = 1'b0;
        o_jump  = JMP_SEQ;
        o_br    = 1'b0;
        o_brn   = 1'b0;
        o_ill   = 1'b0;
        o_ld    = 1'b0;
        o_st    = 1'b0;
        o_is_br = 1'b0;
        case (w_op)
            OP_R: begin
                o_alu = alu_op(w_f3, w_alt);
                o_ill = w_f3 == 3'b011;
            end
            OP_IMM: begin
                // ADDI has no SUB form: bit 30 is immediate data except for the shift-right pair
                o_alu  = alu_op(w_f3, w_f3 == 3'b101 && w_alt);
                o_srcb = 1'b1;
                o_ill  = w_f3 == 3'b011;
            end
            OP_LOAD: begin
                o_alu  = ALU_ADD;
                o_srcb = 1'b1;
                o_m2r  = WB_MEM;
                o_ld   = 1'b1;
                o_ill  = w_f3 != 3'b010;
            end
            OP_STORE: begin
                o_alu  = ALU_ADD;
                o_srcb = 1'b1;
                o_imm  = IMM_S;
                o_st   = 1'b1;
                o_ill  = w_f3 != 3'b010;
            end
            OP_BRANCH: begin
                o_alu   = ALU_SUB;
                o_imm   = IMM_B;
                o_is_br = 1'b1;
                o_br    = w_f3 == 3'b000;
                o_brn   = w_f3 == 3'b001;
                o_ill   = w_f3[2:1] != 2'b00;
            end
            OP_JAL: begin
                o_jump = JMP_JAL;
                o_imm  = IMM_J;
                o_m2r  = WB_PC4;
            end
            OP_JALR: begin
                o_jump = JMP_JALR;
                o_alu  = ALU_ADD;
                o_srcb = 1'b1;
                o_m2r  = WB_PC4;
                o_ill  = w_f3 != 3'b000;
            end
            OP_LUI: begin
                o_imm = IMM_U;
                o_m2r = WB_IMM;
            end
            default: o_ill = 1'b1;
        endcase
    end
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath
//   clk, rst (sync, active-low)   inst_field [31:0] IR word   mem_ready memory done
//   mem_req, mem_we, ir_ce, pc_ce, RegWrite   handshake and write strobes
//   ALU_Control, ImmSel, MemtoReg, ALUSrc_B, Jump, Branch, BranchN   decoded control bus
//   halt, trap_cause   TRAP status (1 illegal instruction, 2 memory timeout)
//   MEM_WAIT_MAX       request cycles without mem_ready tolerated before a timeout trap
//   CPU_CTRL_PERF_CNT_EN  when defined adds cycle_cnt / instret_cnt outputs
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_field,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_ce,
    output logic        pc_ce,
    output logic [3:0]  ALU_Control,
    output logic [2:0]  ImmSel,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrc_B,
    output logic [1:0]  Jump,
    output logic        Branch,
    output logic        BranchN,
    output logic        RegWrite,
    output logic        halt,
    output logic [1:0]  trap_cause
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);
    localparam logic [8:0] WAIT_LIM = 9'(MEM_WAIT_MAX);
    state_t     r_state, w_next;
    logic       r_live;
    logic [7:0] r_wait;
    logic [1:0] r_cause, w_cause;
    logic [3:0] w_alu;
    logic [2:0] w_imm;
    logic [1:0] w_m2r, w_jump;
    logic       w_srcb, w_br, w_brn, w_ill, w_ld, w_st, w_is_br, w_show, w_expire;
    cpu_ctrl_decode u_dec (
        .i_inst (inst_field),
        .o_alu  (w_alu),
        .o_imm  (w_imm),
        .o_m2r  (w_m2r),
        .o_srcb (w_srcb),
        .o_jump (w_jump),
        .o_br   (w_br),
        .o_brn  (w_brn),
        .o_ill  (w_ill),
        .o_ld   (w_ld),
        .o_st   (w_st),
        .o_is_br(w_is_br)
    );
    // r_live holds every output at 0 through the cycle in which reset is being released
    assign w_show      = r_live && r_state inside {DECODE, EXEC, MEM, WB};
    assign ALU_Control = w_show ? w_alu : '0;
    assign ImmSel      = w_show ? w_imm : '0;
    assign MemtoReg    = w_show ? w_m2r : '0;
    assign ALUSrc_B    = w_show && w_srcb;
    assign Jump        = w_show ? w_jump : '0;
    assign Branch      = w_show && w_br;
    assign BranchN     = w_show && w_brn;
    assign halt        = r_state == TRAP;
    assign trap_cause  = r_cause;
    // this cycle would be the MEM_WAIT_MAX-th request cycle without a ready
    assign w_expire    = ({1'b0, r_wait} + 9'd1) == WAIT_LIM;
    always_comb begin
        w_next   = r_state;
        w_cause  = r_cause;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_ce    = 1'b0;
        pc_ce    = 1'b0;
        RegWrite = 1'b0;
        if (r_live) begin
            case (r_state)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_ce   = mem_ready;
                    w_next  = mem_ready ? DECODE : w_expire ? TRAP : FETCH;
                    w_cause = !mem_ready && w_expire ? TRAP_MEM : r_cause;
                end
                DECODE: begin
                    w_next  = w_ill ? TRAP : EXEC;
                    w_cause = w_ill ? TRAP_ILLEGAL : r_cause;
                end
                EXEC: begin
                    pc_ce    = !(w_ld || w_st);
                    RegWrite = !(w_ld || w_st || w_is_br);
                    w_next   = w_ld || w_st ? MEM : FETCH;
                end
                MEM: begin
                    mem_req = 1'b1;
                    mem_we  = w_st;
                    pc_ce   = mem_ready && w_st;
                    w_next  = mem_ready ? (w_st ? FETCH : WB) : w_expire ? TRAP : MEM;
                    w_cause = !mem_ready && w_expire ? TRAP_MEM : r_cause;
                end
                WB: begin
                    RegWrite = 1'b1;
                    pc_ce    = 1'b1;
                    w_next   = FETCH;
                end
                default: w_next = TRAP;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FETCH;
            r_live  <= 1'b0;
            r_wait  <= '0;
            r_cause <= TRAP_NONE;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            r_wait  <= mem_req && !mem_ready ? r_wait + 8'd1 : 8'd0;
            r_cause <= w_cause;
        end
    end
`ifdef CPU_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + {31'd0, r_live};
            instret_cnt <= instret_cnt + {31'd0, pc_ce};
        end
    end
`endif
endmodule
